// File: rtl/wbq_pkg.sv
// Purpose : shared widths, the hardwired-zero register index and the queue entry type.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// The entry fields define the stored widths. The wb_queue ADDR_W/DATA_W parameters
// must stay equal to WBQ_ADDR_W/WBQ_DATA_W.
package wbq_pkg;

   localparam int WBQ_ADDR_W = 5;
   localparam int WBQ_DATA_W = 32;

   localparam logic [WBQ_ADDR_W-1:0] REG_ZERO = '0;

   // "reg" is a keyword, so the destination field is called regidx.
   typedef struct packed {
      logic                  valid;
      logic [WBQ_ADDR_W-1:0] regidx;
      logic [WBQ_DATA_W-1:0] data;
   } wbq_entry_t;

endpackage

// File: rtl/wbq_cam_match.sv
// Purpose : associative lookup of one read address against every queued entry.
// Latency : combinational.
// Backpressure : none; a pure function of the entry array, rd_ptr and addr.
// Ports   : ent[DEPTH] entry array, rd_ptr head index, addr query register,
//           hit any valid entry targets addr (never for register 0),
//           mdata data of the youngest matching entry (0 when no hit).
module wbq_cam_match
   import wbq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  wbq_entry_t              ent [DEPTH],
   input  logic [PTR_W-1:0]        rd_ptr,
   input  logic [WBQ_ADDR_W-1:0]   addr,
   output logic                    hit,
   output logic [WBQ_DATA_W-1:0]   mdata
);

   logic [PTR_W-1:0] idx;

   // Walk the slots oldest to youngest, starting at the head. A later match
   // overwrites an earlier one, so the entry nearest the write pointer wins.
   always_comb begin
      hit   = 1'b0;
      mdata = '0;
      idx   = rd_ptr;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr + PTR_W'(k);
         if (ent[idx].valid && (ent[idx].regidx == addr) && (addr != REG_ZERO)) begin
            hit   = 1'b1;
            mdata = ent[idx].data;
         end
      end
   end

endmodule

// File: rtl/wb_queue.sv
// Purpose : buffers producer results and retires one per cycle, oldest first, into the register-file write port.
// Latency : an entry pushed into an empty, unstalled queue drives RegWrite in the next cycle. There is no same-cycle pass-through.
// Backpressure : in_ready = !full, even when a pop happens in the same cycle. wb_stall holds the head entry.
// Ports   : clk, reset (synchronous, active high);
//           in_valid/in_ready/in_reg/in_data producer push handshake;
//           wb_stall holds retirement; RegWrite/WriteRegister/WriteData write port;
//           rd_addr1/2 decode read addresses -> pend1/2 hazard flags,
//           byp_hit1/2 + byp_data1/2 youngest queued data;
//           count occupancy.
// Config  : define WBQ_BYPASS_EN to drive the byp_* outputs. Otherwise they are tied to 0.
module wb_queue
   import wbq_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = WBQ_ADDR_W,
   parameter int DATA_W = WBQ_DATA_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [ADDR_W-1:0]           in_reg,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        wb_stall,
   output logic                        RegWrite,
   output logic [ADDR_W-1:0]           WriteRegister,
   output logic [DATA_W-1:0]           WriteData,
   input  logic [ADDR_W-1:0]           rd_addr1,
   input  logic [ADDR_W-1:0]           rd_addr2,
   output logic                        pend1,
   output logic                        pend2,
   output logic                        byp_hit1,
   output logic                        byp_hit2,
   output logic [DATA_W-1:0]           byp_data1,
   output logic [DATA_W-1:0]           byp_data2,
   output logic [$clog2(DEPTH+1)-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   wbq_entry_t        q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   logic              hit1;
   logic              hit2;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign in_ready = !full;

   // A register-0 result completes the handshake but is dropped, because
   // writing it would have no effect.
   assign push = in_valid && in_ready && (in_reg != REG_ZERO);
   assign pop  = RegWrite;

   assign RegWrite      = !empty && !wb_stall;
   assign WriteRegister = empty ? '0 : q[rd_ptr].regidx;
   assign WriteData     = empty ? '0 : q[rd_ptr].data;

   // The write and read slots are the same only when the queue is empty (no pop)
   // or full (no push), so the two slot updates below never collide.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q[i].valid <= 1'b0;
         end
      end else begin
         if (push) begin
            q[wr_ptr].valid  <= 1'b1;
            q[wr_ptr].regidx <= in_reg;
            q[wr_ptr].data   <= in_data;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            q[rd_ptr].valid <= 1'b0;
            rd_ptr          <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef WBQ_BYPASS_EN
   logic [DATA_W-1:0] bd1;
   logic [DATA_W-1:0] bd2;
`endif

   wbq_cam_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_cam1 (
      .ent    (q),
      .rd_ptr (rd_ptr),
      .addr   (rd_addr1),
      .hit    (hit1),
`ifdef WBQ_BYPASS_EN
      .mdata  (bd1)
`else
      .mdata  ()
`endif
   );

   wbq_cam_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_cam2 (
      .ent    (q),
      .rd_ptr (rd_ptr),
      .addr   (rd_addr2),
      .hit    (hit2),
`ifdef WBQ_BYPASS_EN
      .mdata  (bd2)
`else
      .mdata  ()
`endif
   );

   assign pend1 = hit1;
   assign pend2 = hit2;

`ifdef WBQ_BYPASS_EN
   assign byp_hit1  = hit1;
   assign byp_hit2  = hit2;
   assign byp_data1 = bd1;
   assign byp_data2 = bd2;
`else
   assign byp_hit1  = 1'b0;
   assign byp_hit2  = 1'b0;
   assign byp_data1 = '0;
   assign byp_data2 = '0;
`endif

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-side initiator for the 32x32 register file; converts producer results into the register file's single write port (RegWrite, WriteRegister, WriteData).
- Buffers up to DEPTH pending results in a FIFO and retires at most one per cycle, oldest first.
- Reports per-read-port hazards (register has a pending write) so decode can stall.
- Sits between the execute/memory result mux and the register file.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a result.
- in_ready  out  1  queue can accept; equals !full.
- in_reg  in  ADDR_W  destination register.
- in_data  in  DATA_W  result value.
- wb_stall  in  1  when 1, the queue does not retire an entry this cycle.
- RegWrite  out  1  write strobe to the register file.
- WriteRegister  out  ADDR_W  head entry register index.
- WriteData  out  DATA_W  head entry data.
- rd_addr1, rd_addr2  in  ADDR_W  read addresses currently in decode.
- pend1, pend2  out  1  a queued write targets rd_addrN.
- byp_hit1, byp_hit2  out  1  bypass data valid (see Optional Feature).
- byp_data1, byp_data2  out  DATA_W  youngest queued data for rd_addrN.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset: count=0, rd/wr pointers=0, RegWrite=0, WriteRegister=0, WriteData=0, pend*=0, byp*=0, in_ready=1 in the cycle after reset. Reset mid-operation flushes all entries. Queued writes are lost.
- Accept: push when in_valid && in_ready at a posedge.
- Register 0 is never written. A push with in_reg==0 is accepted (handshake completes) but does not allocate an entry or change count.
- Retire: RegWrite = !empty && !wb_stall, combinational. WriteRegister and WriteData are driven from the head entry whenever non-empty, and are 0 when empty. Head pops at the posedge where RegWrite=1.
- Latency: an entry pushed at edge N drives RegWrite in cycle N+1 if the queue was empty and not stalled. The register file captures it at edge N+1. No same-cycle pass-through.
- Simultaneous push and pop: count unchanged; both pointers advance.
- When full, in_ready=0 even if a pop occurs that cycle. No full-throughput-when-full.
- Pointers wrap modulo DEPTH. count saturates naturally: it never exceeds DEPTH and never goes below 0.
- Hazard: pendN = OR over valid entries of (entry.reg == rd_addrN). pendN is forced to 0 when rd_addrN==0. The head entry counts while it is still queued, including during the cycle it is being written. Combinational from state and rd_addrN.
- Duplicate destinations may coexist. Retire order is strictly FIFO, so the final register value is the youngest.

Optional Feature:
- Macro WBQ_BYPASS_EN.
- Defined: byp_hitN = pendN. byp_dataN = data of the youngest valid entry matching rd_addrN; priority goes to the entry nearest the write pointer.
- Undefined: byp_hit1/2 and byp_data1/2 are tied to 0. The port list is unchanged.

Decomposition:
- Package wbq_pkg holds:
  - ADDR_W/DATA_W defaults;
  - REG_ZERO constant (0);
  - typedef wbq_entry_t {valid, reg, data}.
- One sub-module, wbq_cam_match: given the entry array, pointers and one query address, returns hit and youngest-match data. It is instantiated twice, once per read port.

Test Plan:
- Reset, then push (reg=3, data=0x1111_2222) → next cycle RegWrite=1, WriteRegister=3, WriteData=0x11112222; the cycle after, RegWrite=0 and count=0.
- With wb_stall=1, push 4 entries (regs 1,2,3,4) → count=4, in_ready=0. A fifth push is not accepted. Release stall → writes retire in order 1,2,3,4 on consecutive cycles.
- Push reg=0 data=0xDEAD → in_ready stays 1, count stays 0, RegWrite never asserts, and pend1=0 with rd_addr1=0.
- Stall, push (5, 0xA) then (5, 0xB), rd_addr1=5 → pend1=1. With WBQ_BYPASS_EN, byp_data1=0xB. Release stall → RegWrite 5/0xA then 5/0xB.
- Full queue, unstalled, in_valid=1 → push accepted only after the first pop frees space; count never exceeds 4.
- Assert reset with 3 entries queued → next cycle count=0, RegWrite=0, pend1/pend2=0.
